// File: rtl/render_scheduler.sv
// render_scheduler: per-pixel layer select (fill / maze tile / sprite) for the
// colour path. Three-stage pipeline; character slots swap in at frame start.
module render_scheduler #(
   parameter int NUM_CHARS = 5,
   parameter int H_TILES   = 28,
   parameter int V_TILES   = 36
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_pix_valid,
   input  logic [9:0] i_pix_x,
   input  logic [9:0] i_pix_y,
   input  logic       i_frame_start,
   input  logic       i_char_wr,
   input  logic [2:0] i_char_idx,
   input  logic       i_char_en,
   input  logic [9:0] i_char_x,
   input  logic [9:0] i_char_y,
   input  logic [7:0] i_char_sprite,
   output logic [9:0] o_map_addr,
   input  logic [7:0] i_map_tile,
   output logic       o_pix_valid,
   output logic [1:0] o_mem_select,
   output logic [7:0] o_address_map,
   output logic [7:0] o_address_char,
   output logic [5:0] o_tile_offset,
   output logic [5:0] o_char_offset
);

   localparam logic [10:0] X_LIM = 11'(8 * H_TILES);
   localparam logic [10:0] Y_LIM = 11'(8 * V_TILES);
   localparam logic [3:0]  N_LIM = 4'(NUM_CHARS);

   logic       sh_en  [NUM_CHARS];
   logic [9:0] sh_x   [NUM_CHARS];
   logic [9:0] sh_y   [NUM_CHARS];
   logic [7:0] sh_spr [NUM_CHARS];
   logic       ac_en  [NUM_CHARS];
   logic [9:0] ac_x   [NUM_CHARS];
   logic [9:0] ac_y   [NUM_CHARS];
   logic [7:0] ac_spr [NUM_CHARS];

   logic wr_ok;
   assign wr_ok = i_char_wr && ({1'b0, i_char_idx} < N_LIM);

   // A write landing on the frame-start cycle is forwarded into the active copy.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_CHARS; i++) begin
            sh_en[i]  <= 1'b0;
            sh_x[i]   <= '0;
            sh_y[i]   <= '0;
            sh_spr[i] <= '0;
            ac_en[i]  <= 1'b0;
            ac_x[i]   <= '0;
            ac_y[i]   <= '0;
            ac_spr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CHARS; i++) begin
            if (wr_ok && i_char_idx == 3'(i)) begin
               sh_en[i]  <= i_char_en;
               sh_x[i]   <= i_char_x;
               sh_y[i]   <= i_char_y;
               sh_spr[i] <= i_char_sprite;
            end
            if (i_frame_start) begin
               if (wr_ok && i_char_idx == 3'(i)) begin
                  ac_en[i]  <= i_char_en;
                  ac_x[i]   <= i_char_x;
                  ac_y[i]   <= i_char_y;
                  ac_spr[i] <= i_char_sprite;
               end else begin
                  ac_en[i]  <= sh_en[i];
                  ac_x[i]   <= sh_x[i];
                  ac_y[i]   <= sh_y[i];
                  ac_spr[i] <= sh_spr[i];
               end
            end
         end
      end
   end

   logic [9:0] addr_c;
   logic       in_field_c;
   logic       hit_c;
   logic [7:0] spr_c;
   logic [5:0] coff_c;

   assign addr_c = 10'(i_pix_y[9:3]) * 10'(H_TILES) + 10'(i_pix_x[9:3]);
   assign in_field_c = ({1'b0, i_pix_x} < X_LIM) && ({1'b0, i_pix_y} < Y_LIM);

   // Descending scan so the lowest-index hit is the one left standing.
   always_comb begin
      hit_c  = 1'b0;
      spr_c  = '0;
      coff_c = '0;
      for (int i = NUM_CHARS - 1; i >= 0; i--) begin
         if (ac_en[i]
             && {1'b0, i_pix_x} >= {1'b0, ac_x[i]}
             && {1'b0, i_pix_x} <  {1'b0, ac_x[i]} + 11'd8
             && {1'b0, i_pix_y} >= {1'b0, ac_y[i]}
             && {1'b0, i_pix_y} <  {1'b0, ac_y[i]} + 11'd8) begin
            hit_c  = 1'b1;
            spr_c  = ac_spr[i];
            coff_c = {i_pix_y[2:0] - ac_y[i][2:0],
                      i_pix_x[2:0] - ac_x[i][2:0]};
         end
      end
   end

   logic       s1_valid, s1_in, s1_hit;
   logic [7:0] s1_spr;
   logic [5:0] s1_coff, s1_toff;
   logic       s2_valid, s2_in, s2_hit;
   logic [7:0] s2_spr;
   logic [5:0] s2_coff, s2_toff;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_map_addr <= '0;
         s1_valid   <= 1'b0;
         s1_in      <= 1'b0;
         s1_hit     <= 1'b0;
         s1_spr     <= '0;
         s1_coff    <= '0;
         s1_toff    <= '0;
         s2_valid   <= 1'b0;
         s2_in      <= 1'b0;
         s2_hit     <= 1'b0;
         s2_spr     <= '0;
         s2_coff    <= '0;
         s2_toff    <= '0;
      end else begin
         if (i_pix_valid && in_field_c)
            o_map_addr <= addr_c;
         s1_valid <= i_pix_valid;
         s1_in    <= in_field_c;
         s1_hit   <= hit_c;
         s1_spr   <= spr_c;
         s1_coff  <= coff_c;
         s1_toff  <= {i_pix_y[2:0], i_pix_x[2:0]};
         s2_valid <= s1_valid;
         s2_in    <= s1_in;
         s2_hit   <= s1_hit;
         s2_spr   <= s1_spr;
         s2_coff  <= s1_coff;
         s2_toff  <= s1_toff;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_pix_valid    <= 1'b0;
         o_mem_select   <= 2'b00;
         o_address_map  <= '0;
         o_address_char <= '0;
         o_tile_offset  <= '0;
         o_char_offset  <= '0;
      end else begin
         o_pix_valid    <= s2_valid;
         o_mem_select   <= 2'b00;
         o_address_map  <= '0;
         o_address_char <= '0;
         o_tile_offset  <= '0;
         o_char_offset  <= '0;
         if (s2_valid && s2_in) begin
            o_mem_select  <= s2_hit ? 2'b11 : 2'b01;
            o_address_map <= i_map_tile;
            o_tile_offset <= s2_toff;
            if (s2_hit) begin
               o_address_char <= s2_spr;
               o_char_offset  <= s2_coff;
            end
         end
      end
   end

endmodule

// File: tb/tb_render_scheduler.sv
// Directed bench for render_scheduler: scoreboard of expected pixels,
// checked three cycles after each is driven, with a map RAM model.
module tb_render_scheduler;

   typedef struct packed {
      logic       v;
      logic [1:0] sel;
      logic [7:0] amap;
      logic [7:0] achar;
      logic [5:0] toff;
      logic [5:0] coff;
   } out_t;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic       i_pix_valid;
   logic [9:0] i_pix_x, i_pix_y;
   logic       i_frame_start;
   logic       i_char_wr;
   logic [2:0] i_char_idx;
   logic       i_char_en;
   logic [9:0] i_char_x, i_char_y;
   logic [7:0] i_char_sprite;
   logic [9:0] o_map_addr;
   logic [7:0] i_map_tile;
   logic       o_pix_valid;
   logic [1:0] o_mem_select;
   logic [7:0] o_address_map, o_address_char;
   logic [5:0] o_tile_offset, o_char_offset;

   render_scheduler dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_pix_valid(i_pix_valid), .i_pix_x(i_pix_x), .i_pix_y(i_pix_y),
      .i_frame_start(i_frame_start),
      .i_char_wr(i_char_wr), .i_char_idx(i_char_idx),
      .i_char_en(i_char_en), .i_char_x(i_char_x), .i_char_y(i_char_y),
      .i_char_sprite(i_char_sprite),
      .o_map_addr(o_map_addr), .i_map_tile(i_map_tile),
      .o_pix_valid(o_pix_valid), .o_mem_select(o_mem_select),
      .o_address_map(o_address_map), .o_address_char(o_address_char),
      .o_tile_offset(o_tile_offset), .o_char_offset(o_char_offset)
   );

   always #5 i_clk = ~i_clk;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   logic chk_on = 1'b0;
   out_t q_exp[$];
   int   q_due[$];
   out_t got, ex;

   int m_sen[8], m_sx[8], m_sy[8], m_ss[8];
   int m_aen[8], m_ax[8], m_ay[8], m_as[8];

   always @(posedge i_clk) cyc <= cyc + 1;

   function automatic logic [7:0] ram_f(int a);
      return 8'((a * 7 + 5) & 255);
   endfunction

   always @(posedge i_clk) i_map_tile <= ram_f(int'(o_map_addr));

   function automatic out_t model(int x, int y);
      out_t r;
      int   a;
      bit   found;
      r = '0;
      r.v = 1'b1;
      found = 0;
      if (x >= 224 || y >= 288) return r;
      a = (y / 8) * 28 + x / 8;
      r.sel  = 2'b01;
      r.amap = ram_f(a);
      r.toff = 6'((y % 8) * 8 + x % 8);
      for (int i = 0; i < 5; i++) begin
         if (!found && m_aen[i] != 0 && x >= m_ax[i] && x < m_ax[i] + 8
             && y >= m_ay[i] && y < m_ay[i] + 8) begin
            found   = 1;
            r.sel   = 2'b11;
            r.achar = 8'(m_as[i]);
            r.coff  = 6'((y - m_ay[i]) * 8 + (x - m_ax[i]));
         end
      end
      return r;
   endfunction

   always @(negedge i_clk) begin
      if (chk_on) begin
         got = {o_pix_valid, o_mem_select, o_address_map,
                o_address_char, o_tile_offset, o_char_offset};
         if (q_due.size() != 0 && q_due[0] == cyc) begin
            ex = q_exp.pop_front();
            void'(q_due.pop_front());
            n_vec++;
            assert (got === ex) else begin
               n_err++;
               $error("FAIL pixel cyc=%0d got=%h exp=%h", cyc, got, ex);
            end
         end else begin
            n_vec++;
            assert (got === '0) else begin
               n_err++;
               $error("FAIL idle cyc=%0d got=%h exp=0", cyc, got);
            end
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic pix(int x, int y);
      i_pix_valid = 1'b1;
      i_pix_x = 10'(x);
      i_pix_y = 10'(y);
      q_exp.push_back(model(x, y));
      q_due.push_back(cyc + 3);
      tick();
      i_pix_valid = 1'b0;
   endtask

   task automatic idle(int n);
      i_pix_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic wr(int idx, int en, int x, int y, int spr, bit fs);
      i_char_wr = 1'b1;
      i_char_idx = 3'(idx);
      i_char_en = en[0];
      i_char_x = 10'(x);
      i_char_y = 10'(y);
      i_char_sprite = 8'(spr);
      i_frame_start = fs;
      if (idx < 5) begin
         m_sen[idx] = en; m_sx[idx] = x; m_sy[idx] = y; m_ss[idx] = spr;
      end
      if (fs) begin
         m_aen = m_sen; m_ax = m_sx; m_ay = m_sy; m_as = m_ss;
      end
      tick();
      i_char_wr = 1'b0;
      i_frame_start = 1'b0;
   endtask

   task automatic frame();
      i_frame_start = 1'b1;
      m_aen = m_sen; m_ax = m_sx; m_ay = m_sy; m_as = m_ss;
      tick();
      i_frame_start = 1'b0;
   endtask

   task automatic chk_addr(string tag, logic [9:0] exp_a);
      n_vec++;
      assert (o_map_addr === exp_a) else begin
         n_err++;
         $error("FAIL %s got=%0d exp=%0d", tag, o_map_addr, exp_a);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 8; i++) begin
         m_sen[i] = 0; m_sx[i] = 0; m_sy[i] = 0; m_ss[i] = 0;
         m_aen[i] = 0; m_ax[i] = 0; m_ay[i] = 0; m_as[i] = 0;
      end
      i_rst_n = 1'b0;
      i_pix_valid = 1'b0; i_pix_x = '0; i_pix_y = '0;
      i_frame_start = 1'b0; i_char_wr = 1'b0; i_char_idx = '0;
      i_char_en = 1'b0; i_char_x = '0; i_char_y = '0; i_char_sprite = '0;
      repeat (3) tick();
      got = {o_pix_valid, o_mem_select, o_address_map,
             o_address_char, o_tile_offset, o_char_offset};
      n_vec++;
      assert (got === '0) else begin
         n_err++;
         $error("FAIL reset_out got=%h exp=0", got);
      end
      chk_addr("reset_addr", 10'd0);
      i_rst_n = 1'b1;
      chk_on = 1'b1;
      idle(2);

      pix(0, 0);
      chk_addr("addr_0_0", 10'd0);
      idle(3);
      pix(13, 18);
      chk_addr("addr_13_18", 10'd57);
      pix(224, 10);
      chk_addr("addr_hold_x", 10'd57);
      pix(5, 288);
      chk_addr("addr_hold_y", 10'd57);
      pix(223, 287);
      chk_addr("addr_corner", 10'd1007);
      idle(3);

      wr(0, 1, 100, 50, 8'h10, 1'b0);
      pix(103, 52);
      frame();
      pix(103, 52);
      pix(108, 52);
      idle(3);

      wr(1, 1, 40, 40, 8'h21, 1'b0);
      wr(3, 1, 40, 40, 8'h23, 1'b0);
      frame();
      pix(41, 41);
      wr(1, 0, 40, 40, 8'h21, 1'b0);
      pix(41, 41);
      frame();
      pix(41, 41);
      idle(3);

      wr(0, 1, 200, 50, 8'h10, 1'b0);
      pix(103, 52);
      pix(203, 52);
      wr(6, 1, 0, 0, 8'h66, 1'b0);
      frame();
      pix(103, 52);
      pix(203, 52);
      pix(1, 1);
      wr(2, 1, 60, 60, 8'h32, 1'b1);
      pix(61, 61);
      pix(68, 61);
      wr(4, 1, 220, 10, 8'h44, 1'b1);
      pix(221, 12);
      pix(225, 12);
      idle(3);

      for (int i = 0; i < 1000; i++)
         pix((i * 5) % 240, (i * 3) % 300);
      idle(6);

      n_vec++;
      assert (q_due.size() == 0) else begin
         n_err++;
         $error("FAIL drain got=%0d pending exp=0", q_due.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/render_scheduler.md
Name: render_scheduler

Overview:
- Per-pixel scheduler for the memory/colour path: decides, for every VGA pixel, whether the maze tile layer, a character sprite, or the out-of-playfield fill is shown.
- Generates the map-RAM fetch address and drives the select, address and offset inputs of the memory controller.
- Sits between the VGA timing generator / game logic and the memory controller.
- Holds double-buffered character position registers so that moves only take effect at frame boundaries.

Parameters:
- NUM_CHARS, 5, number of character slots (Pac-Man plus 4 ghosts); 1..8.
- H_TILES, 28, playfield width in 8x8 tiles.
- V_TILES, 36, playfield height in 8x8 tiles.

Ports:
- i_clk  in  1  system/pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_pix_valid  in  1  pixel coordinate valid this cycle
- i_pix_x  in  10  pixel column
- i_pix_y  in  10  pixel row
- i_frame_start  in  1  one-cycle pulse at start of vertical blank
- i_char_wr  in  1  write strobe for character shadow slot
- i_char_idx  in  3  slot index
- i_char_en  in  1  slot enable (drawn when 1)
- i_char_x  in  10  sprite top-left column
- i_char_y  in  10  sprite top-left row
- i_char_sprite  in  8  sprite id for the char memory
- o_map_addr  out  10  maze map RAM address (RAM has 1-cycle registered read)
- i_map_tile  in  8  tile id returned by map RAM
- o_pix_valid  out  1  outputs below correspond to a pixel
- o_mem_select  out  2  00 fill, 01 tile, 11 char
- o_address_map  out  8  tile id
- o_address_char  out  8  sprite id
- o_tile_offset  out  6  offset within tile, row*8+col
- o_char_offset  out  6  offset within sprite, row*8+col

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0; all shadow and active slot registers 0, so every slot is disabled.
- Shadow write: when i_char_wr=1 and i_char_idx<NUM_CHARS, shadow[idx] takes en/x/y/sprite. An idx>=NUM_CHARS is ignored.
- Active copy: on i_frame_start, active[*] takes shadow[*]. A write in the same cycle is forwarded, so the copied slot carries the new values.
- Rendering uses active registers only. Writes mid-frame do not change the picture until the next i_frame_start.
- Pipeline: fixed 3 cycles, fully pipelined, one pixel per cycle, no stalls.
- S0 (cycle T): sample i_pix_valid, i_pix_x, i_pix_y.
- S1 (T+1), o_map_addr is registered:
  - o_map_addr = (y>>3)*H_TILES + (x>>3).
  - in_field = x < 8*H_TILES && y < 8*V_TILES.
  - Char hit test for each enabled slot: cx <= x < cx+8 and cy <= y < cy+8. Compute cx+8 and cy+8 at 11 bits (no wrap).
  - Winner is the lowest index hit. Register its sprite id and offset (y-cy)*8 + (x-cx).
  - Register tile offset = y[2:0]*8 + x[2:0].
  - When out of field, o_map_addr holds its previous value.
- S2 (T+2): the map RAM presents i_map_tile. It is captured together with the S1 results into the output registers, visible at T+3.
- Output selection, registered at T+3:
  - !valid: o_pix_valid=0, o_mem_select=00, other outputs 0.
  - valid and !in_field: o_mem_select=00.
  - valid, in_field, char hit: o_mem_select=11, o_address_char=sprite, o_char_offset=char offset, o_address_map=i_map_tile, o_tile_offset=tile offset.
  - valid, in_field, no hit: o_mem_select=01, o_address_map=i_map_tile, o_tile_offset, o_address_char=0, o_char_offset=0.
- Sprites are clipped to the playfield: a char over a pixel outside the field still yields 00.
- Reset mid-frame: the pipeline flushes to zeros immediately; the first valid output appears 3 cycles after the first post-reset i_pix_valid.

Test Plan:
- Reset then idle: outputs all 0; pix (0,0) valid at T, no chars → T+1 o_map_addr=0; map RAM returns 0x05 → T+3 select=01, address_map=0x05, tile_offset=0.
- Pixel (13,18), no chars → o_map_addr=2*28+1=57, tile_offset=2*8+5=21, select=01.
- Slot0 (en, x=100, y=50, sprite 0x10) written, then frame_start; pixel (103,52) → select=11, address_char=0x10, char_offset=19. Pixel (108,52) → select=01.
- Slots 1 and 3 overlap at (40,40) with sprites 0x21 and 0x23 → pixel (41,41) gives address_char=0x21. Disable slot1 and frame_start → 0x23.
- Write slot0 to x=200 without frame_start → old position still drawn. Write with idx=6 and NUM_CHARS=5 → no change. Write coincident with frame_start → new value drawn next frame.
- Pixel (224,10) or (5,288), or char at x=220 with pixel x=225 → select=00. Stream of 1000 consecutive valid pixels → every output exactly 3 cycles after its input, no bubbles.
